// File: rtl/uart_cmd_trigger_pkg.sv
// Shared types and constants for the UART command trigger block:
// FSM encodings, ASCII codes of the default command characters and
// a small width helper.
package uart_cmd_trigger_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_FIRE  = 2'd2
  } state_t;

  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_R = 8'h52;

  // Channel 0 sits in the low byte: H=0, B=1, D=2, R=3.
  localparam logic [31:0] DEF_CMD_CHARS = {CH_R, CH_D, CH_B, CH_H};

  // Width of a channel index; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_trigger_pulse_timer.sv
// Down-counter that times the trigger pulse. Loaded with (width-1) on
// entry to FIRE; busy stays high until it has counted down to zero.
module pulse_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] count,
  output logic       busy
);

  logic [7:0] r_cnt;

  // Reload on request, otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (load) begin
      r_cnt <= count;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign busy = (r_cnt != 8'd0);

endmodule

// File: rtl/uart_cmd_trigger.sv
// UART command trigger: fires trig[i] after REPEAT_COUNT consecutive
// copies of command character i arrive on the received byte stream.
// Optional inter-byte timeout, pulse or level style output.
module uart_cmd_trigger
  import uart_cmd_trigger_pkg::*;
#(
  parameter int                    NUM_CMDS       = 4,
  parameter logic [NUM_CMDS*8-1:0] CMD_CHARS      = DEF_CMD_CHARS,
  parameter int                    REPEAT_COUNT   = 10,
  parameter int                    TIMEOUT_CYCLES = 0,
  parameter int                    PULSE_CYCLES   = 16,
  localparam int                   IDX_W          = idx_width(NUM_CMDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          uart_data,
  input  logic                uart_ready,
  output logic [NUM_CMDS-1:0] trig,
  output logic                trig_any,
  output logic [IDX_W-1:0]    last_cmd,
  output logic [7:0]          progress
);

  localparam int             GAP_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] TO_G     = GAP_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]     RC8        = 8'(REPEAT_COUNT);
  localparam logic           PULSE_MODE = (PULSE_CYCLES > 0);
  localparam logic [7:0]     PULSE_LOAD = 8'(PULSE_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_progress, w_progress_nxt;
  logic [IDX_W-1:0]     r_last, w_last_nxt;
  logic [GAP_W-1:0]     r_gap, w_gap_nxt;
  logic [GAP_W-1:0]     w_gap_inc;
  logic [NUM_CMDS-1:0]  r_trig, w_trig_nxt;
  logic                 r_trig_any;
  logic [NUM_CMDS-1:0]  w_hit;
  logic                 w_any_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_same;
  logic                 w_load;
  logic                 w_busy;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CMDS; gi++) begin : g_match
      assign w_hit[gi] = (uart_data == CMD_CHARS[8*gi +: 8]);
    end
  endgenerate

  assign w_any_hit = |w_hit;
  assign w_same    = (uart_data == CMD_CHARS[8*r_last +: 8]);
  assign w_gap_inc = r_gap + GAP_W'(1);

  // Priority encoder: lowest matching channel index wins.
  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_idx = IDX_W'(i);
      end else begin
        w_hit_idx = w_hit_idx;
      end
    end
  end

  // The pulse timer only ever loads in pulse mode; in level mode it idles.
  assign w_load = PULSE_MODE && (w_state_nxt == S_FIRE) && (r_state != S_FIRE);

  pulse_timer u_pulse_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .count (PULSE_LOAD),
    .busy  (w_busy)
  );

  // State register together with the registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_progress <= 8'd0;
      r_last     <= '0;
      r_gap      <= '0;
      r_trig     <= '0;
      r_trig_any <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_progress <= w_progress_nxt;
      r_last     <= w_last_nxt;
      r_gap      <= w_gap_nxt;
      r_trig     <= w_trig_nxt;
      r_trig_any <= |w_trig_nxt;
    end
  end

  // Next-state and counter logic for the match / count / fire sequence.
  always_comb begin
    w_state_nxt    = r_state;
    w_progress_nxt = r_progress;
    w_last_nxt     = r_last;
    w_gap_nxt      = r_gap;
    case (r_state)
      S_IDLE: begin
        if (uart_ready && w_any_hit) begin
          w_last_nxt     = w_hit_idx;
          w_progress_nxt = 8'd1;
          w_gap_nxt      = '0;
          w_state_nxt    = (REPEAT_COUNT == 1) ? S_FIRE : S_COUNT;
        end else if (uart_ready) begin
          w_progress_nxt = 8'd0;
        end else begin
          w_progress_nxt = r_progress;
        end
      end
      S_COUNT: begin
        // A byte always beats an expiring gap timer.
        if (uart_ready && w_same) begin
          w_progress_nxt = r_progress + 8'd1;
          w_gap_nxt      = '0;
          if ((r_progress + 8'd1) == RC8) begin
            w_state_nxt = S_FIRE;
          end else begin
            w_state_nxt = S_COUNT;
          end
        end else if (uart_ready && w_any_hit) begin
          w_last_nxt     = w_hit_idx;
          w_progress_nxt = 8'd1;
          w_gap_nxt      = '0;
          w_state_nxt    = S_COUNT;
        end else if (uart_ready) begin
          w_progress_nxt = 8'd0;
          w_gap_nxt      = '0;
          w_state_nxt    = S_IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (w_gap_inc == TO_G) begin
            w_progress_nxt = 8'd0;
            w_gap_nxt      = '0;
            w_state_nxt    = S_IDLE;
          end else begin
            w_gap_nxt = w_gap_inc;
          end
        end else begin
          w_gap_nxt = r_gap;
        end
      end
      S_FIRE: begin
        if (PULSE_MODE) begin
          // Bytes are discarded for the whole pulse.
          if (!w_busy) begin
            w_progress_nxt = 8'd0;
            w_state_nxt    = S_IDLE;
          end else begin
            w_state_nxt = S_FIRE;
          end
        end else if (uart_ready && w_same) begin
          w_progress_nxt = RC8;
        end else if (uart_ready && w_any_hit) begin
          w_last_nxt     = w_hit_idx;
          w_progress_nxt = 8'd1;
          w_gap_nxt      = '0;
          w_state_nxt    = (REPEAT_COUNT == 1) ? S_FIRE : S_COUNT;
        end else if (uart_ready) begin
          w_progress_nxt = 8'd0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_state_nxt = S_FIRE;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_progress_nxt = 8'd0;
        w_gap_nxt      = '0;
      end
    endcase
  end

  // Trigger vector for the next cycle: one-hot on the active channel in FIRE.
  always_comb begin
    w_trig_nxt = '0;
    if (w_state_nxt == S_FIRE) begin
      w_trig_nxt[w_last_nxt] = 1'b1;
    end else begin
      w_trig_nxt = '0;
    end
  end

  // Reset removes the trigger immediately, without waiting for the clock edge.
  assign trig     = r_trig & {NUM_CMDS{~rst}};
  assign trig_any = r_trig_any & ~rst;
  assign last_cmd = r_last;
  assign progress = r_progress;

endmodule
